// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the async FIFO control stages.
//   FIFO_PTR_W  default pointer width (MSB is the wrap bit)
//   DEPTH       entries addressed by a FIFO_PTR_W pointer
//   ptr_t       default-width pointer vector
//   gray2bin    Gray-to-binary conversion for any width up to 32
//   full_match  Gray full compare, shared with the read-side empty logic
package fifo_pkg;

  localparam int unsigned FIFO_PTR_W = 4;
  localparam int unsigned DEPTH      = 1 << (FIFO_PTR_W - 1);

  typedef logic [FIFO_PTR_W-1:0] ptr_t;

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  // Prefix XOR from the MSB down, done as log2 shift steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    b = g & width_mask(w);
    for (int unsigned s = 1; s < 32; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  // Full when the write pointer equals the read pointer with its top two
  // Gray bits inverted (one full lap ahead).
  function automatic logic full_match(input logic [31:0] wr_gray, input logic [31:0] rd_gray,
                                      input int unsigned w);
    logic [31:0] flip;
    flip = 32'd3 << (w - 2);
    return ((wr_gray ^ rd_gray ^ flip) & width_mask(w)) == '0;
  endfunction

endpackage

// File: rtl/sync_vec.sv
// sync_vec: multi-flop vector synchronizer, no logic between stages.
//   clk    destination clock
//   rst    asynchronous active-high reset, clears every stage
//   d      asynchronous input vector (expected Gray-coded)
//   q      output of the last stage
module sync_vec #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain control stage of the async FIFO.
//   clk, reset     write clock, asynchronous active-high reset
//   wr_push        write request, one entry per cycle
//   overflow_clr   clears the sticky overflow flag
//   wr_gray_i      registered Gray write pointer returned by wr_ptr_gray
//   rd_gray_async  Gray read pointer from the read clock domain
//   wr_inc/mem_we  accepted push: advances wr_ptr_gray and writes the RAM
//   wr_addr        RAM write address (current pointer, low bits)
//   full           FIFO full, from registered signals only
//   level          registered fill level, 0..2^(PTR_W-1)
//   overflow       sticky: a push was dropped while full
//   almost_full    registered level >= AF_THRESH, only with FIFO_WR_ALMOST_FULL_EN
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_W       = FIFO_PTR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_push,
  input  logic             overflow_clr,
  input  logic [PTR_W-1:0] wr_gray_i,
  input  logic [PTR_W-1:0] rd_gray_async,
  output logic             wr_inc,
  output logic             mem_we,
  output logic [PTR_W-2:0] wr_addr,
  output logic             full,
  output logic [PTR_W-1:0] level,
  output logic             overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic             almost_full
`endif
);

  logic [PTR_W-1:0] rd_gray_s;
  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] rd_bin_s;
  logic             accept;
  logic [PTR_W-1:0] level_d, level_q;
  logic             overflow_d, overflow_q;

  sync_vec #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (clk),
    .rst (reset),
    .d   (rd_gray_async),
    .q   (rd_gray_s)
  );

  always_comb begin
    wr_bin   = PTR_W'(gray2bin(32'(wr_gray_i), PTR_W));
    rd_bin_s = PTR_W'(gray2bin(32'(rd_gray_s), PTR_W));
    full     = full_match(32'(wr_gray_i), 32'(rd_gray_s), PTR_W);
    // reset gates the push so nothing leaks into wr_ptr_gray while it is held.
    accept   = wr_push & ~full & ~reset;
    wr_inc   = accept;
    mem_we   = accept;
    wr_addr  = wr_bin[PTR_W-2:0];
  end

  always_comb begin
    level_d = wr_bin - rd_bin_s;
    overflow_d = overflow_q;
    // set has priority over clear
    if (wr_push & full) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic almost_full_d, almost_full_q;

  // Compared against the next level so it asserts together with level.
  always_comb begin
    almost_full_d = 32'(level_d) >= AF_THRESH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl. The wr_ptr_gray
// neighbour is emulated here; the reference model tracks total pushes and
// pops as plain integers and a delay line for the synchronized read count.
module tb_fifo_wr_ctrl;

  localparam int unsigned PW  = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned AF  = 6;
  localparam int          DEP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_push;
  logic          overflow_clr;
  logic [PW-1:0] wr_gray_i;
  logic [PW-1:0] rd_gray_async;
  logic          wr_inc;
  logic          mem_we;
  logic [PW-2:0] wr_addr;
  logic          full;
  logic [PW-1:0] level;
  logic          overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_wr_ctrl #(
    .PTR_W       (PW),
    .SYNC_STAGES (SS),
    .AF_THRESH   (AF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_push       (wr_push),
    .overflow_clr  (overflow_clr),
    .wr_gray_i     (wr_gray_i),
    .rd_gray_async (rd_gray_async),
    .wr_inc        (wr_inc),
    .mem_we        (mem_we),
    .wr_addr       (wr_addr),
    .full          (full),
    .level         (level),
    .overflow      (overflow)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .almost_full   (almost_full)
`endif
  );

  always #5 clk = ~clk;

  // wr_ptr_gray neighbour: binary counter advanced by wr_inc, Gray output.
  logic [PW-1:0] wr_bin_nb;
  always @(posedge clk or posedge reset) begin
    if (reset) wr_bin_nb <= '0;
    else if (wr_inc) wr_bin_nb <= wr_bin_nb + 1'b1;
  end
  assign wr_gray_i = wr_bin_nb ^ (wr_bin_nb >> 1);

  int n_checks = 0;
  int n_errors = 0;

  int wr_tot;          // entries accepted since reset
  int rd_tot;          // entries popped since reset
  int seen [SS];       // read count as seen through the synchronizer
  int exp_level;
  bit exp_ovf;
  bit exp_af;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wr_tot = 0;
    rd_tot = 0;
    for (int i = 0; i < SS; i++) seen[i] = 0;
    exp_level = 0;
    exp_ovf = 0;
    exp_af = 0;
  endtask

  task automatic check_regs(input string phase);
    check_eq({phase, "_level"}, level, exp_level);
    check_eq({phase, "_overflow"}, overflow, exp_ovf);
`ifdef FIFO_WR_ALMOST_FULL_EN
    check_eq({phase, "_almost_full"}, almost_full, exp_af);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_push = 1'b1;
    overflow_clr = 1'b0;
    rd_gray_async = '0;
    model_reset();
    #1;
    check_eq("rst_wr_inc", wr_inc, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_full", full, 0);
    check_regs("rst");
    @(posedge clk);
    #1;
    check_eq("rst_wr_inc_edge", wr_inc, 0);
    check_eq("rst_level_edge", level, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_push = 1'b0;
  endtask

  // One write-clock cycle: drive at negedge, check, then advance the model.
  task automatic step(input bit push, input bit clr, input bit pop, input bit honor);
    bit exp_full, push_eff, acc;
    @(negedge clk);
    if (pop && rd_tot < wr_tot) rd_tot++;
    exp_full = (wr_tot - seen[SS-1]) == DEP;
    push_eff = push && !(honor && exp_full);
    acc = push_eff && !exp_full;
    wr_push = push_eff;
    overflow_clr = clr;
    rd_gray_async = to_gray(rd_tot);
    #1;
    check_eq("full", full, exp_full);
    check_eq("wr_inc", wr_inc, acc);
    check_eq("mem_we", mem_we, acc);
    if (acc) check_eq("wr_addr", wr_addr, wr_tot % DEP);
    check_eq("level_le_depth", level <= DEP, 1);
    check_regs("cyc");
    @(posedge clk);
    if (push_eff && exp_full) exp_ovf = 1;
    else if (clr) exp_ovf = 0;
    exp_level = wr_tot - seen[SS-1];
    exp_af = exp_level >= AF;
    if (acc) wr_tot++;
    for (int i = SS - 1; i > 0; i--) seen[i] = seen[i-1];
    seen[0] = rd_tot;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr_push = 1'b0;
    overflow_clr = 1'b0;
    rd_gray_async = '0;
    model_reset();
    apply_reset();

    // Fill: eight pushes with the read side idle.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    #1;
    check_eq("full_after_8", full, 1);
    check_eq("level_lags_fill", level, 7);
    check_eq("wr_gray_after_8", wr_gray_i, 'hC);
    step(0, 0, 0, 0);
    #1;
    check_eq("level_full", level, 8);

    // Overflow: set, set-beats-clear, clear alone.
    step(1, 0, 0, 0);
    #1;
    check_eq("ovf_set", overflow, 1);
    step(1, 1, 0, 0);
    #1;
    check_eq("ovf_set_wins", overflow, 1);
    step(0, 1, 0, 0);
    #1;
    check_eq("ovf_cleared", overflow, 0);

    // One pop reaches full after two edges and level after three.
    step(0, 0, 1, 0);
    #1;
    check_eq("full_still_1", full, 1);
    step(0, 0, 0, 0);
    #1;
    check_eq("full_dropped", full, 0);
    step(0, 0, 0, 0);
    #1;
    check_eq("level_after_pop", level, 7);
    step(1, 0, 0, 0);
    #1;
    check_eq("wr_gray_after_wrap", wr_gray_i, 'hD);
    check_eq("full_refilled", full, 1);

    // Random traffic honouring full; read side pops ~1/1.7 of cycles.
    for (int i = 0; i < 8000; i++) begin
      step($urandom_range(0, 99) < 60, 0, $urandom_range(0, 999) < 588, 1);
    end
    #1;
    check_eq("no_ovf_when_honoured", overflow, 0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    apply_reset();

    // Random traffic ignoring full, with occasional clears.
    for (int i = 0; i < 8000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 15) == 0,
           $urandom_range(0, 999) < 588, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
